timer_bcd_core: RTL



---
 rtl/timer_bcd_core.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/timer_bcd_core.sv
// Two-digit BCD countdown core with prescaled tick and multiplexed seven-segment drive.
// Optional macro TIMER_AUTORELOAD_EN: reload the last loaded value on expiry instead of stopping in DONE.
module timer_bcd_core #(
    parameter int unsigned PRESCALE = 10_000_000,
    parameter int unsigned MUX_DIV  = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       start,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       done,
    output logic [6:0] seg,
    output logic       digit_sel
);

    localparam int unsigned PW = $clog2(PRESCALE);
    localparam int unsigned MW = $clog2(MUX_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [MW-1:0] MUX_LAST = MW'(MUX_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [MW-1:0] mux_cnt;
    logic          tick;
    logic          count_zero;
    logic          count_one;
    logic [3:0]    shown;

`ifdef TIMER_AUTORELOAD_EN
    logic [3:0]    rl_tens;
    logic [3:0]    rl_ones;
`endif

    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    always_comb begin
        tick       = (state == RUN) && (presc == PRE_LAST);
        count_zero = (tens == 4'd0) && (ones == 4'd0);
        count_one  = (tens == 4'd0) && (ones == 4'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tens    <= '0;
            ones    <= '0;
            running <= 1'b0;
            done    <= 1'b0;
            presc   <= '0;
`ifdef TIMER_AUTORELOAD_EN
            rl_tens <= '0;
            rl_ones <= '0;
`endif
        end else if (load) begin
            state   <= IDLE;
            tens    <= clamp9(load_val[7:4]);
            ones    <= clamp9(load_val[3:0]);
            running <= 1'b0;
            done    <= 1'b0;
            presc   <= '0;
`ifdef TIMER_AUTORELOAD_EN
            rl_tens <= clamp9(load_val[7:4]);
            rl_ones <= clamp9(load_val[3:0]);
`endif
        end else begin
`ifdef TIMER_AUTORELOAD_EN
            done <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (start && !count_zero) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    // The prescaler keeps counting on the pausing cycle, so a start/tick collision drops that tick.
                    presc <= tick ? '0 : presc + PW'(1);
                    if (start) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end else if (tick) begin
                        if (count_one) begin
`ifdef TIMER_AUTORELOAD_EN
                            tens <= rl_tens;
                            ones <= rl_ones;
                            done <= 1'b1;
`else
                            state   <= DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
                            tens    <= '0;
                            ones    <= '0;
`endif
                        end else if (ones != 4'd0) begin
                            ones <= ones - 4'd1;
                        end else begin
                            ones <= 4'd9;
                            tens <= tens - 4'd1;
                        end
                    end
                end
                PAUSE: begin
                    if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                DONE: begin
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mux_cnt   <= '0;
            digit_sel <= 1'b0;
        end else if (mux_cnt == MUX_LAST) begin
            mux_cnt   <= '0;
            digit_sel <= ~digit_sel;
        end else begin
            mux_cnt <= mux_cnt + MW'(1);
        end
    end

    always_comb begin
        shown = digit_sel ? tens : ones;
        unique case (shown)
            4'd0:    seg = 7'b0111111;
            4'd1:    seg = 7'b0000110;
            4'd2:    seg = 7'b1011011;
            4'd3:    seg = 7'b1001111;
            4'd4:    seg = 7'b1100110;
            4'd5:    seg = 7'b1101101;
            4'd6:    seg = 7'b1111101;
            4'd7:    seg = 7'b0000111;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1101111;
            default: seg = 7'b0000000;
        endcase
    end

endmodule
